// File: rtl/sobel_pkg.sv
// Shared Sobel definitions: kernel coefficients, magnitude function and FSM encoding.
package sobel_pkg;

  // Widest pixel the magnitude helper supports; callers zero-extend narrower pixels.
  localparam int unsigned SOBEL_PIX_MAX_W = 16;
  localparam int unsigned SOBEL_MAG_MAX_W = SOBEL_PIX_MAX_W + 3;
  localparam int unsigned SOBEL_ACC_W     = SOBEL_MAG_MAX_W + 1;

  typedef logic        [SOBEL_PIX_MAX_W-1:0] sobel_pix_t;
  typedef logic        [SOBEL_MAG_MAX_W-1:0] sobel_mag_t;
  typedef logic signed [SOBEL_ACC_W-1:0]     sobel_acc_t;

  // Sobel weights: corner taps weigh 1, edge-centre taps weigh 2.
  localparam sobel_acc_t SOBEL_K_SIDE   = sobel_acc_t'(1);
  localparam sobel_acc_t SOBEL_K_CENTRE = sobel_acc_t'(2);

  // Stream FSM encoding.
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  // |Gx|+|Gy| over the 8 neighbours in0..in7 (row-major, centre omitted).
  function automatic sobel_mag_t sobel_mag(
    input sobel_pix_t in0, input sobel_pix_t in1, input sobel_pix_t in2, input sobel_pix_t in3,
    input sobel_pix_t in4, input sobel_pix_t in5, input sobel_pix_t in6, input sobel_pix_t in7
  );
    sobel_acc_t s0, s1, s2, s3, s4, s5, s6, s7;
    sobel_acc_t gx, gy, ax, ay;
    s0 = sobel_acc_t'(in0);
    s1 = sobel_acc_t'(in1);
    s2 = sobel_acc_t'(in2);
    s3 = sobel_acc_t'(in3);
    s4 = sobel_acc_t'(in4);
    s5 = sobel_acc_t'(in5);
    s6 = sobel_acc_t'(in6);
    s7 = sobel_acc_t'(in7);
    gx = (SOBEL_K_SIDE * s2 + SOBEL_K_CENTRE * s4 + SOBEL_K_SIDE * s7)
       - (SOBEL_K_SIDE * s0 + SOBEL_K_CENTRE * s3 + SOBEL_K_SIDE * s5);
    gy = (SOBEL_K_SIDE * s5 + SOBEL_K_CENTRE * s6 + SOBEL_K_SIDE * s7)
       - (SOBEL_K_SIDE * s0 + SOBEL_K_CENTRE * s1 + SOBEL_K_SIDE * s2);
    ax = gx[SOBEL_ACC_W-1] ? -gx : gx;
    ay = gy[SOBEL_ACC_W-1] ? -gy : gy;
    return sobel_mag_t'(ax + ay);
  endfunction

endpackage

// File: rtl/sobel_linebuf.sv
// One image row of delay: read returns the value written at this column on the previous row.
module sobel_linebuf import sobel_pkg::*; #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             en,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] dout
);

  logic [PIX_W-1:0] mem [DEPTH];

  // Asynchronous read so a same-column write this cycle still yields the old row.
  assign dout = mem[addr];

  // Write the current row's pixel over the column just read.
  always_ff @(posedge clk) begin
    if (en) mem[addr] <= din;
  end

endmodule

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with internal line buffers, border zeroing and frame flush.
module sobel_stream import sobel_pkg::*; #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 512,
  parameter int unsigned IMG_H = 512,
  parameter int unsigned MAG_W = PIX_W + 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [MAG_W-1:0] th,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pix,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pix,
  output logic             out_last
);

  localparam int unsigned      COL_W    = $clog2(IMG_W);
  localparam int unsigned      ROW_W    = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [MAG_W-1:0] SAT_MAX  = MAG_W'((2 ** PIX_W) - 1);

  logic [0:0]       state, state_nxt;
  logic             accept, load_out;
  logic [COL_W-1:0] in_col, out_col;
  logic [ROW_W-1:0] in_row, out_row;
  logic             primed, in_end, out_border, out_end;
  logic [PIX_W-1:0] lb1_dout, lb2_dout;
  // Window columns: index 0 = top row, 1 = middle, 2 = bottom.
  logic [PIX_W-1:0] win_l [3];
  logic [PIX_W-1:0] win_c [3];
  logic [PIX_W-1:0] col_n [3];
  logic [MAG_W-1:0] mag;
  logic [PIX_W-1:0] pix_res;

  // Previous row (lb1) and the row before that (lb2), chained.
  sobel_linebuf #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(COL_W)) u_lb1 (
    .clk  (clk),
    .en   (accept),
    .addr (in_col),
    .din  (in_pix),
    .dout (lb1_dout)
  );

  sobel_linebuf #(.DEPTH(IMG_W), .PIX_W(PIX_W), .AW(COL_W)) u_lb2 (
    .clk  (clk),
    .en   (accept),
    .addr (in_col),
    .din  (lb1_dout),
    .dout (lb2_dout)
  );

  // Output k becomes computable once input k+IMG_W+1 arrives, i.e. from pixel (1,1) onward.
  assign primed     = (in_row > ROW_W'(1)) || ((in_row == ROW_W'(1)) && (in_col != '0));
  assign in_end     = (in_row == ROW_LAST) && (in_col == COL_LAST);
  assign out_border = (out_row == '0) || (out_row == ROW_LAST) || (out_col == '0) || (out_col == COL_LAST);
  assign out_end    = (out_row == ROW_LAST) && (out_col == COL_LAST);

  // Next state, input handshake and output-load decision.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    load_out  = 1'b0;
    case (state)
      ST_RUN: begin
        in_ready = rstn && (!out_valid || out_ready);
        accept   = in_valid && in_ready;
        load_out = accept && primed;
        if (accept && in_end) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        load_out = (!out_valid || out_ready) && !(out_valid && out_last);
        if (out_valid && out_ready && out_last) state_nxt = ST_RUN;
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // Incoming column plus kernel evaluation; borders are forced to zero.
  always_comb begin
    col_n[0] = lb2_dout;
    col_n[1] = lb1_dout;
    col_n[2] = in_pix;
    mag = MAG_W'(sobel_mag(
      sobel_pix_t'(win_l[0]), sobel_pix_t'(win_c[0]), sobel_pix_t'(col_n[0]),
      sobel_pix_t'(win_l[1]),                         sobel_pix_t'(col_n[1]),
      sobel_pix_t'(win_l[2]), sobel_pix_t'(win_c[2]), sobel_pix_t'(col_n[2])));
    pix_res = '0;
    if (!out_border) begin
      if (mode) pix_res = (mag > SAT_MAX) ? '1 : PIX_W'(mag);
      else      pix_res = (mag > th) ? '1 : '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_RUN;
    else       state <= state_nxt;
  end

  // Input raster position and 3x3 window shift on every accepted pixel.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      in_col <= '0;
      in_row <= '0;
      for (int i = 0; i < 3; i++) begin
        win_l[i] <= '0;
        win_c[i] <= '0;
      end
    end else if (accept) begin
      if (in_col == COL_LAST) begin
        in_col <= '0;
        in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
      end else begin
        in_col <= in_col + 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        win_l[i] <= win_c[i];
        win_c[i] <= col_n[i];
      end
    end
  end

  // Output register with hold under backpressure and output raster position.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_pix   <= '0;
      out_last  <= 1'b0;
      out_col   <= '0;
      out_row   <= '0;
    end else if (load_out) begin
      out_valid <= 1'b1;
      out_pix   <= pix_res;
      out_last  <= out_end;
      if (out_col == COL_LAST) begin
        out_col <= '0;
        out_row <= (out_row == ROW_LAST) ? '0 : out_row + 1'b1;
      end else begin
        out_col <= out_col + 1'b1;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_stream.sv
// Scoreboard bench for sobel_stream: frame-level reference model, random stalls and gaps.
module tb_sobel_stream;

  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int NPIX  = IMG_W * IMG_H;

  logic        clk = 1'b0;
  logic        rstn;
  logic [10:0] th;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_pix;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pix;
  logic        out_last;

  typedef struct {
    int pix;
    bit last;
  } exp_t;

  exp_t exp_q[$];
  int   img [IMG_H][IMG_W];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   frames_done = 0;
  int   lasts_seen = 0;
  bit   rdy_rand = 1'b0;
  int   gap_pct = 0;

  sobel_stream #(.PIX_W(8), .IMG_W(IMG_W), .IMG_H(IMG_H), .MAG_W(11)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .th        (th),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: direct Sobel sum on the stored frame, borders zero.
  function automatic int model_pix(input int r, input int c, input int md, input int t);
    int gx, gy, mag;
    if (r == 0 || r == IMG_H - 1 || c == 0 || c == IMG_W - 1) return 0;
    gx = (img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1])
       - (img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1]);
    gy = (img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1])
       - (img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    if (md != 0) return (mag > 255) ? 255 : mag;
    return (mag > t) ? 255 : 0;
  endfunction

  task automatic fill_step(input int lo, input int hi);
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = (c < 4) ? lo : hi;
  endtask

  task automatic fill_random();
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = int'($urandom_range(255));
  endtask

  // Queue expectations for the whole frame, then stream it; n_stop < NPIX aborts early.
  task automatic send_frame(input int md, input int t, input int n_stop);
    exp_t e;
    bit   ok;
    int   waited;
    th   = 11'(t);
    mode = 1'(md);
    for (int k = 0; k < NPIX; k++) begin
      e.pix  = model_pix(k / IMG_W, k % IMG_W, md, t);
      e.last = (k == NPIX - 1);
      exp_q.push_back(e);
    end
    for (int k = 0; k < n_stop; k++) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        repeat (int'($urandom_range(3, 1))) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_pix   = 8'(img[k / IMG_W][k % IMG_W]);
      waited   = 0;
      ok       = 1'b0;
      while (!ok && waited < 300) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
        waited++;
      end
      if (!ok) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_accept_timeout: pixel %0d not accepted within %0d cycles", k, waited);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    if (n_stop == NPIX) frames_done++;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 3000) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_remaining", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_out_last", out_last, 0);
    check("rst_in_ready", in_ready, 0);
  endtask

  // Random or always-on downstream ready, changed just after each edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rdy_rand ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  // Monitor: pop and compare on every handshake; check hold under stall and in_ready during flush.
  initial begin
    bit       prev_stall = 1'b0;
    int       prev_pix = 0;
    int       prev_last = 0;
    exp_t     e;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1) begin
        if (prev_stall) begin
          check("hold_valid", out_valid, 1);
          check("hold_pix", out_pix, prev_pix);
          check("hold_last", out_last, prev_last);
        end
        if (frames_done > lasts_seen) check("in_ready_flush", in_ready, 0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL extra_output: got pix %0d with no output expected", out_pix);
          end else begin
            e = exp_q.pop_front();
            check("out_pix", out_pix, e.pix);
            check("out_last", out_last, int'(e.last));
            if (e.last) lasts_seen++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_pix   = int'(out_pix);
        prev_last  = int'(out_last);
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_pix   = '0;
    th       = 11'd50;
    mode     = 1'b0;
    repeat (2) @(posedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;

    // Flat field: no edges anywhere.
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = 8'h80;
    send_frame(0, 50, NPIX);
    drain();

    // Vertical step of 100, binary and magnitude modes.
    fill_step(0, 100);
    send_frame(0, 50, NPIX);
    drain();
    send_frame(1, 50, NPIX);
    drain();

    // Step of 16 gives mag 64: threshold equality and one below.
    fill_step(0, 16);
    send_frame(0, 64, NPIX);
    drain();
    send_frame(0, 63, NPIX);
    drain();
    send_frame(1, 64, NPIX);
    drain();

    // Same step with random backpressure and input gaps.
    rdy_rand = 1'b1;
    gap_pct  = 30;
    fill_step(0, 100);
    send_frame(0, 50, NPIX);
    drain();
    send_frame(1, 50, NPIX);
    drain();
    rdy_rand = 1'b0;
    gap_pct  = 0;

    // Abort a frame after 20 inputs, reset, then a clean step frame.
    fill_random();
    send_frame(0, 50, 20);
    rstn = 1'b0;
    exp_q.delete();
    @(posedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    fill_step(0, 100);
    send_frame(0, 50, NPIX);
    drain();

    // Back-to-back frames under random backpressure: flat then step.
    rdy_rand = 1'b1;
    for (int r = 0; r < IMG_H; r++)
      for (int c = 0; c < IMG_W; c++)
        img[r][c] = 8'h80;
    send_frame(0, 50, NPIX);
    fill_step(0, 100);
    send_frame(0, 50, NPIX);
    drain();

    // Random images, thresholds and modes with stalls.
    gap_pct = 20;
    for (int f = 0; f < 4; f++) begin
      fill_random();
      send_frame(f % 2, int'($urandom_range(600)), NPIX);
      drain();
    end
    rdy_rand = 1'b0;
    gap_pct  = 0;
    repeat (4) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
Streaming Sobel edge detector. It takes a raster-order grayscale pixel stream and produces one output pixel per input pixel. It holds two line buffers internally and builds the 3x3 window itself, so upstream logic no longer has to gather neighbours. It is the parametrised successor to the single-window 8-input kernel, adding valid/ready handshakes, frame counting, border handling and a magnitude output mode.

Parameters:
PIX_W, 8, input/output pixel width in bits.
IMG_W, 512, pixels per row (>=3).
IMG_H, 512, rows per frame (>=3).
MAG_W, PIX_W+3, width of |Gx|+|Gy|; max value 8*(2^PIX_W-1).

Ports:
clk  in  1  rising-edge clock.
rstn  in  1  synchronous active-low reset.
th  in  MAG_W  edge threshold; sampled every cycle, must be static within a frame.
mode  in  1  0 = binary (edge -> all ones, else 0); 1 = saturated magnitude.
in_valid  in  1  in_pix valid.
in_ready  out  1  block accepts in_pix this cycle.
in_pix  in  PIX_W  raster-order pixel.
out_valid  out  1  out_pix valid.
out_ready  in  1  downstream accepts out_pix.
out_pix  out  PIX_W  result pixel.
out_last  out  1  high with the final pixel of a frame (index IMG_W*IMG_H-1).

Behaviour:
- Reset (rstn=0 at a clk edge): out_valid=0, out_pix=0, out_last=0, in_ready=0 for that cycle. State goes to RUN, all counters go to 0, window registers go to 0. Line buffer contents are don't-care. Reset mid-frame discards the partial frame; the next accepted pixel is pixel (0,0).
- Transfers occur only when valid&&ready on the same edge.
- Window: centre (r,c) uses neighbours In0..In7 as (r-1,c-1),(r-1,c),(r-1,c+1),(r,c-1),(r,c+1),(r+1,c-1),(r+1,c),(r+1,c+1).
- Gx = (In2+2*In4+In7)-(In0+2*In3+In5); Gy = (In5+2*In6+In7)-(In0+2*In1+In2). Use signed MAG_W+1 intermediates; mag = |Gx|+|Gy| as unsigned MAG_W, no overflow possible.
- Mode 0: out_pix = (mag > th) ? all ones : 0. Equality gives 0.
- Mode 1: out_pix = min(mag, 2^PIX_W-1).
- Border pixels (r=0, r=IMG_H-1, c=0, c=IMG_W-1) output 0 in both modes.
- Latency: output for index k (k=r*IMG_W+c) is registered on the edge following acceptance of input index k+IMG_W+1. Latency is therefore IMG_W+1 accepted inputs plus 1 clk.
- FSM:
  - RUN: in_ready = !out_valid || out_ready. After the first IMG_W+1 accepts of a frame, every accept loads one output.
  - On acceptance of input index IMG_W*IMG_H-1 -> FLUSH.
  - FLUSH: in_ready=0. Emits the remaining IMG_W+1 outputs, all border zeros, one per cycle while !out_valid||out_ready. The last one carries out_last=1. After it is accepted -> RUN with counters at 0.
  - Back-to-back frames are allowed. A new frame's input is accepted only after FLUSH completes.
- Backpressure: out_valid/out_pix/out_last hold stable while out_valid && !out_ready. No output is dropped or duplicated. Exactly IMG_W*IMG_H outputs per frame.
- Column/row counters wrap at IMG_W-1 / IMG_H-1.
- The line buffer read and write of the same column in one cycle returns the old (previous-row) data.

Decomposition:
- sobel_pkg holds: the function computing mag from eight pixels, the sobel coefficient constants, and the FSM state encoding (RUN, FLUSH).
- One sub-module, sobel_linebuf: IMG_W-deep, PIX_W-wide shift/RAM line buffer with enable. Instantiate it twice, chained.

Test Plan:
- Use IMG_W=8, IMG_H=6, PIX_W=8, th=50 unless stated.
- Flat frame, all pixels 0x80, mode 0 -> 48 outputs all 0x00; out_last only on the 48th.
- Vertical step (cols 0-3 = 0, cols 4-7 = 100), mode 0 -> rows 1-4 have 0xFF at cols 3 and 4 (mag 400), 0x00 elsewhere. Mode 1 -> 0xFF (saturated from 400) at the same positions.
- Threshold edge: step height 16 (mag 64), th=64 -> 0x00; th=63 -> 0xFF at cols 3,4. Mode 1 -> 0x40.
- Random out_ready (50%) and random in_valid gaps on the step frame -> output sequence identical to the no-stall run. No change of out_pix while stalled. Count is 48.
- Reset mid-frame after 20 inputs, then a full step frame -> exactly 48 outputs matching the step case, with no residue from the aborted frame.
- Two back-to-back frames (flat, then step) -> in_ready low during FLUSH; 96 outputs with out_last at outputs 48 and 96; second frame matches the step case.
